// File: rtl/display_scan.sv
// Multiplexed 4-digit common-anode seven-segment scanner with per-slot blanking and shadow latching.
// Optional macro DISPLAY_SCAN_BRIGHTNESS_EN adds a 4-bit PWM brightness input.
module display_scan #(
  parameter logic [15:0] REFRESH_DIV  = 16'd50000,
  parameter logic [15:0] BLANK_CYCLES = 16'd500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] segment0,
  input  logic [7:0] segment1,
  input  logic [7:0] segment2,
  input  logic [7:0] segment3,
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
  input  logic [3:0] brightness,
`endif
  output logic [3:0] anode,
  output logic [7:0] cathode,
  output logic [1:0] digit,
  output logic       frame_tick
);

  localparam logic [15:0] LAST_CNT = REFRESH_DIV - 16'd1;

  logic [15:0] div_cnt_q, div_cnt_d;
  logic [1:0]  digit_q, digit_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [3:0]  anode_q, anode_d;
  logic [7:0]  cathode_q, cathode_d;
  logic [1:0]  digit_out_q, digit_out_d;
  logic        frame_tick_q, frame_tick_d;
  logic [7:0]  sel;
  logic [7:0]  pattern;
  logic        blank;
  logic        lit;

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;
`endif

  always_comb begin
    sel = segment0;
    case (digit_q)
      2'd0: sel = segment0;
      2'd1: sel = segment1;
      2'd2: sel = segment2;
      2'd3: sel = segment3;
      default: sel = segment0;
    endcase

    // div_cnt < BLANK_CYCLES, written so BLANK_CYCLES == 0 is not a constant-false compare
    blank = ({1'b0, div_cnt_q} + 17'd1) <= {1'b0, BLANK_CYCLES};

    // On the latch edge the new value is shown directly; when blanking is on that edge is dark anyway
    pattern = (div_cnt_q == '0) ? sel : shadow_q;

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    lit       = (brightness == 4'hF) || (pwm_cnt_q < brightness);
    pwm_cnt_d = pwm_cnt_q + 4'd1;
`else
    lit = 1'b1;
`endif

    div_cnt_d = div_cnt_q + 16'd1;
    digit_d   = digit_q;
    if (div_cnt_q == LAST_CNT) begin
      div_cnt_d = '0;
      digit_d   = digit_q + 2'd1;
    end

    shadow_d = (div_cnt_q == '0) ? sel : shadow_q;

    if (blank || !lit) begin
      anode_d   = '1;
      cathode_d = '1;
    end else begin
      anode_d   = ~(4'b0001 << digit_q);
      cathode_d = ~pattern;
    end

    digit_out_d  = digit_q;
    frame_tick_d = (digit_q == 2'd3) && (div_cnt_q == LAST_CNT);

    // Disabled behaves exactly like reset: scanner parked at its start point, display dark
    if (!enable) begin
      div_cnt_d    = '0;
      digit_d      = '0;
      shadow_d     = '0;
      anode_d      = '1;
      cathode_d    = '1;
      digit_out_d  = '0;
      frame_tick_d = 1'b0;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
      pwm_cnt_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_q    <= '0;
      digit_q      <= '0;
      shadow_q     <= '0;
      anode_q      <= '1;
      cathode_q    <= '1;
      digit_out_q  <= '0;
      frame_tick_q <= 1'b0;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
      pwm_cnt_q    <= '0;
`endif
    end else begin
      div_cnt_q    <= div_cnt_d;
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      digit_out_q  <= digit_out_d;
      frame_tick_q <= frame_tick_d;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
      pwm_cnt_q    <= pwm_cnt_d;
`endif
    end
  end

  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign digit      = digit_out_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: constant vector table, directed corner sequences and a
// randomized run against a slot-arithmetic reference model (one DUT with blanking, one without).
module tb_display_scan;

  localparam int unsigned R = 8;
  localparam int unsigned B = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] seg0 = 8'h00, seg1 = 8'h00, seg2 = 8'h00, seg3 = 8'h00;
  logic [3:0] br = 4'hF;

  logic [3:0] an_a, an_b;
  logic [7:0] ca_a, ca_b;
  logic [1:0] dg_a, dg_b;
  logic       ft_a, ft_b;

  int checks = 0;
  int errors = 0;

  // Model state: edges since last restart, and the pattern latched for the current slot
  int unsigned m_t = 0;
  logic [7:0]  m_sh = 8'h00;

  always #5 clk = ~clk;

  display_scan #(.REFRESH_DIV(16'd8), .BLANK_CYCLES(16'd2)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .segment0(seg0), .segment1(seg1), .segment2(seg2), .segment3(seg3),
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    .brightness(br),
`endif
    .anode(an_a), .cathode(ca_a), .digit(dg_a), .frame_tick(ft_a)
  );

  display_scan #(.REFRESH_DIV(16'd8), .BLANK_CYCLES(16'd0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable),
    .segment0(seg0), .segment1(seg1), .segment2(seg2), .segment3(seg3),
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    .brightness(br),
`endif
    .anode(an_b), .cathode(ca_b), .digit(dg_b), .frame_tick(ft_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input int unsigned d);
    case (d)
      0: return seg0;
      1: return seg1;
      2: return seg2;
      default: return seg3;
    endcase
  endfunction

  // One clock edge: model predicts both DUTs, outputs compared #1 later
  task automatic step();
    logic [3:0] e_an_a, e_an_b, one;
    logic [7:0] e_ca_a, e_ca_b;
    logic [1:0] e_dg;
    logic       e_ft, lit;
    int unsigned div, dgi, pw;
    one = 4'b0001;
    @(posedge clk);
    if (!reset || !enable) begin
      e_an_a = 4'hF; e_an_b = 4'hF; e_ca_a = 8'hFF; e_ca_b = 8'hFF;
      e_dg = 2'd0; e_ft = 1'b0;
      m_t = 0; m_sh = 8'h00;
    end else begin
      div = m_t % R;
      dgi = (m_t / R) % 4;
      pw  = m_t % 16;
      if (div == 0) m_sh = seg_of(dgi);
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
      lit = (br == 4'hF) || (pw < int'(br));
`else
      lit = 1'b1;
`endif
      if (div < B || !lit) begin e_an_a = 4'hF; e_ca_a = 8'hFF; end
      else begin e_an_a = ~(one << dgi); e_ca_a = ~m_sh; end
      if (!lit) begin e_an_b = 4'hF; e_ca_b = 8'hFF; end
      else begin e_an_b = ~(one << dgi); e_ca_b = ~m_sh; end
      e_dg = dgi[1:0];
      e_ft = (dgi == 3) && (div == R - 1);
      m_t++;
    end
    #1;
    check("anode_a", 32'(an_a), 32'(e_an_a));
    check("cathode_a", 32'(ca_a), 32'(e_ca_a));
    check("digit_a", 32'(dg_a), 32'(e_dg));
    check("tick_a", 32'(ft_a), 32'(e_ft));
    check("anode_b", 32'(an_b), 32'(e_an_b));
    check("cathode_b", 32'(ca_b), 32'(e_ca_b));
    check("digit_b", 32'(dg_b), 32'(e_dg));
    check("tick_b", 32'(ft_b), 32'(e_ft));
  endtask

  // Advance until the next edge is at frame position pos (0..31)
  task automatic run_to(input int unsigned pos);
    for (int unsigned i = 0; i < 64; i++) begin
      if (m_t % (4 * R) == pos) return;
      step();
    end
    check("run_to_reached", 32'(m_t % (4 * R)), 32'(pos));
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] an;
    logic [7:0] ca;
    logic [1:0] dg;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [3:0] slot_an[4];
    logic [7:0] slot_ca[4];
    int ticks, first_tick, lit_cnt;

    tbl[0] = '{1'b0, 1'b1, 4'hF, 8'hFF, 2'd0};
    tbl[1] = '{1'b1, 1'b1, 4'hF, 8'hFF, 2'd0};
    tbl[2] = '{1'b1, 1'b1, 4'hF, 8'hFF, 2'd0};
    for (int i = 3; i < 9; i++) tbl[i] = '{1'b1, 1'b1, 4'hE, 8'hC0, 2'd0};
    tbl[9] = '{1'b1, 1'b1, 4'hF, 8'hFF, 2'd1};
    slot_an = '{4'hE, 4'hD, 4'hB, 4'h7};
    slot_ca = '{8'hF9, 8'hA4, 8'hB0, 8'h99};

    // Reset, then digit 0 = 8'h3F through its blank and drive portions
    seg0 = 8'h3F;
    for (int i = 0; i < 10; i++) begin
      reset = tbl[i].rst;
      enable = tbl[i].en;
      step();
      check("tbl_anode", 32'(an_a), 32'(tbl[i].an));
      check("tbl_cathode", 32'(ca_a), 32'(tbl[i].ca));
      check("tbl_digit", 32'(dg_a), 32'(tbl[i].dg));
    end

    // Full frames with four patterns; frame_tick on the last digit-3 edge
    seg0 = 8'h06; seg1 = 8'h5B; seg2 = 8'h4F; seg3 = 8'h66;
    reset = 1'b0; step(); reset = 1'b1;
    ticks = 0; first_tick = -1;
    for (int k = 0; k < 64; k++) begin
      step();
      if (ft_a) begin
        ticks++;
        if (first_tick < 0) first_tick = k;
      end
      if (k % 8 == 4) begin
        check("slot_anode", 32'(an_a), 32'(slot_an[(k / 8) % 4]));
        check("slot_cathode", 32'(ca_a), 32'(slot_ca[(k / 8) % 4]));
      end
    end
    check("tick_count", 32'(ticks), 32'd2);
    check("tick_first", 32'(first_tick), 32'd31);

    // Mid-slot write to segment1 only shows in the following slot-1 pass
    run_to(12);
    seg1 = 8'h7F;
    for (int k = 0; k < 4; k++) begin
      step();
      check("midslot_hold", 32'(ca_a), 32'h A4);
    end
    run_to(10);
    step();
    check("next_slot1", 32'(ca_a), 32'h80);

    // Drop enable mid slot 2, then restart from digit 0 with blanking
    run_to(20);
    enable = 1'b0;
    step();
    check("dis_anode", 32'(an_a), 32'hF);
    check("dis_digit", 32'(dg_a), 32'd0);
    step();
    enable = 1'b1;
    step(); check("reen_blank0", 32'(an_a), 32'hF);
    step(); check("reen_blank1", 32'(an_a), 32'hF);
    step();
    check("reen_anode", 32'(an_a), 32'hE);
    check("reen_cathode", 32'(ca_a), 32'hF9);

    // Reset mid slot 3
    run_to(28);
    reset = 1'b0;
    step();
    check("rst_anode", 32'(an_a), 32'hF);
    check("rst_cathode", 32'(ca_a), 32'hFF);
    check("rst_digit", 32'(dg_a), 32'd0);
    reset = 1'b1;

    // No-blanking instance drives the new pattern on the very first slot-2 edge
    seg2 = 8'h6D;
    run_to(16);
    step();
    check("b0_first_anode", 32'(an_b), 32'hB);
    check("b0_first_cathode", 32'(ca_b), 32'h92);

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    br = 4'h0;
    lit_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (an_a != 4'hF) lit_cnt++;
    end
    check("dark_count", 32'(lit_cnt), 32'd0);
    br = 4'h4;
    for (int k = 0; k < 64; k++) step();
    br = 4'hF;
`else
    lit_cnt = 0;
`endif

    // Randomized run against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(7) == 0) seg0 = 8'($urandom);
      if ($urandom_range(7) == 0) seg1 = 8'($urandom);
      if ($urandom_range(7) == 0) seg2 = 8'($urandom);
      if ($urandom_range(7) == 0) seg3 = 8'($urandom);
      enable = ($urandom_range(63) != 0);
      reset  = ($urandom_range(127) != 0);
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
      if ($urandom_range(99) == 0) br = 4'($urandom);
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
